rom_burst_reader: RTL
=====================

// Module: rom_burst_reader
// PURPOSE
//   Parametrised synchronous ROM with a burst-read engine and valid/ready handshakes. A requester
//   posts a start address and a beat count. The block streams consecutive words, wrapping at DEPTH.
//   Output data is registered and held under backpressure.
//   Intended as the generic lookup/table source feeding downstream datapaths in the mem/ library.
// PARAMETERS
//   DATA_W     8            word width in bits
//   ADDR_W     6            address / length field width
//   DEPTH      1<<ADDR_W    number of ROM words; 1 <= DEPTH <= 2**ADDR_W
//   INIT_MODE  0            content pattern: 0 -> rom[i]=i mod 2**DATA_W; 1 -> rom[i]=~(i mod 2**DATA_W)
// PORTS
//   clk        in   1       clock; all logic on posedge
//   reset      in   1       synchronous reset, active-low
//   req_valid  in   1       burst request present
//   req_ready  out  1       block can accept a request
//   req_addr   in   ADDR_W  first word address
//   req_len    in   ADDR_W  beats minus one (0 = single word, max 2**ADDR_W beats)
//   rd_valid   out  1       rd_data/rd_last valid
//   rd_ready   in   1       consumer accepts current beat
//   rd_data    out  DATA_W  ROM word
//   rd_last    out  1       current beat is final beat of burst
//   busy       out  1       burst in progress (state BURST)
//   err        out  1       one-cycle pulse: request rejected, req_addr >= DEPTH
// BEHAVIOUR
//   - Reset (reset==0 at posedge): state=IDLE; rd_valid=0, rd_data=0, rd_last=0, err=0, busy=0,
//     internal addr/beat counters=0. Reset wins over every other event, including mid-burst;
//     the burst is abandoned with no further beats. ROM contents are fixed and unaffected by reset.
//   - FSM states: IDLE, BURST. req_ready = (state==IDLE); combinational from state only.
//   - Accept: req_valid && req_ready at posedge.
//     - If req_addr < DEPTH: the same edge loads rd_data=rom[req_addr], rd_valid=1,
//       rd_last=(req_len==0), next_addr=req_addr+1 (wrapped), remaining=req_len, state=BURST.
//       Latency is therefore 1 cycle, from accepting edge to rd_valid high.
//     - If req_addr >= DEPTH (possible only when DEPTH < 2**ADDR_W): err=1 for exactly one cycle.
//       State stays IDLE and no beats are produced. err=0 on every other cycle.
//   - Beat transfer: rd_valid && rd_ready at posedge.
//     - If remaining != 0: rd_data=rom[next_addr], next_addr advances, remaining decrements,
//       rd_last=(remaining==1). rd_valid stays 1, giving back-to-back beats at full rate.
//     - If remaining == 0 (rd_last was 1): rd_valid=0, rd_last=0, state=IDLE.
//       rd_data holds its last value.
//   - Backpressure: while rd_valid && !rd_ready, rd_data, rd_last, rd_valid and the counters hold.
//   - Address wrap: the successor of DEPTH-1 is 0, for any DEPTH (not only powers of two).
//     Bursts longer than DEPTH re-read words cyclically.
//   - req_valid in BURST is ignored (req_ready=0). The requester holds its request until accepted.
//     After a final beat there is one IDLE cycle before the next request can be accepted.
//   - busy = (state==BURST). rd_valid implies busy.
//   - Width rules: remaining is ADDR_W bits, with no overflow since req_len <= 2**ADDR_W-1.
//     Content index i is truncated to DATA_W bits when DATA_W < ADDR_W.
//     It is zero-extended when DATA_W > ADDR_W.
// TESTING (DATA_W=8, ADDR_W=6, DEPTH=64, INIT_MODE=0 unless stated)
//   1. Single read: reset low 2 cycles, then addr=32, len=0, rd_ready=1
//      -> next cycle rd_valid=1, rd_data=32, rd_last=1; following cycle rd_valid=0, req_ready=1.
//   2. Burst with wrap: addr=62, len=3, rd_ready=1
//      -> rd_data 62, 63, 0, 1 on consecutive cycles; rd_last only on 1; then IDLE.
//   3. Backpressure: addr=10, len=2; drop rd_ready for 3 cycles after first beat
//      -> rd_data holds 10 with rd_valid=1; then 11, 12 with rd_last on 12; no beats lost or duplicated.
//   4. Reset mid-burst: addr=39, len=7; assert reset after beat 41
//      -> next cycle rd_valid=0, rd_data=0, busy=0, req_ready=1; a new request addr=50, len=0 returns 50.
//   5. DEPTH=48 build: addr=50 -> err=1 for one cycle, rd_valid stays 0.
//      Then addr=46, len=2 -> 46, 47, 0.
//   6. INIT_MODE=1, addr=5, len=1 -> rd_data 0xFA, 0xF9.
//      Assert req_valid during burst -> ignored, req_ready=0 throughout.

Source files
------------

// File: rtl/rom_burst_reader.sv
// Parametrised synchronous ROM with a burst-read engine and valid/ready handshakes.
// Streams consecutive words from a start address, wrapping at DEPTH, with registered held output.
module rom_burst_reader #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 1 << ADDR_W,
    parameter int INIT_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_len,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              err
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    // ROM content is a pure function of the index, so no storage array is needed
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] w;
        w = DATA_W'(idx);
        return (INIT_MODE == 1) ? ~w : w;
    endfunction

    function automatic logic [ADDR_W-1:0] succ(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if ({1'b0, req_addr} < DEPTH_EXT) begin
                        data_d  = rom_word(req_addr);
                        valid_d = 1'b1;
                        last_d  = (req_len == '0);
                        addr_d  = succ(req_addr);
                        rem_d   = req_len;
                        state_d = BURST;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BURST: begin
                if (valid_q && rd_ready) begin
                    if (rem_q != '0) begin
                        data_d = rom_word(addr_q);
                        addr_d = succ(addr_q);
                        rem_d  = rem_q - ADDR_W'(1);
                        last_d = (rem_q == ADDR_W'(1));
                    end else begin
                        // rd_data deliberately keeps the final beat
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q == BURST);
    assign rd_valid  = valid_q;
    assign rd_data   = data_q;
    assign rd_last   = last_q;
    assign err       = err_q;

endmodule
